// File: rtl/seq_abacus_if.sv
// Operand/result bundle for seq_abacus: the request side drives operands and
// start, the unit drives the handshake status and the registered result.
interface seq_abacus_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   in1;
    logic [W-1:0]   in2;
    logic [1:0]     sel;
    logic           ready;
    logic           done;
    logic           overflow;
    logic [2*W-1:0] out_reg;

    modport master (
        output start, in1, in2, sel,
        input  ready, done, overflow, out_reg
    );

    modport slave (
        input  start, in1, in2, sel,
        output ready, done, overflow, out_reg
    );
endinterface

// File: rtl/seq_abacus.sv
// Multi-cycle unsigned arithmetic unit: single-cycle add/sub, iterative
// shift-add multiply and restoring divide, with a one-cycle done pulse.
module seq_abacus #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_abacus_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0]     state_r;
    logic           ready_r;
    logic           done_r;
    logic           overflow_r;
    logic [2*W-1:0] out_r;
    logic [CW-1:0]  cnt_r;
    logic [2*W-1:0] work_r;
    logic [W-1:0]   opnd_r;
    logic           is_mul_r;

    logic [W:0]     add_sum_s;
    logic [W-1:0]   sub_diff_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     div_shift_s;
    logic [W-1:0]   div_rem_s;
    logic           div_take_s;
    logic [2*W-1:0] work_nxt_s;

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;
    assign bus.out_reg  = out_r;

    // Single-cycle results, computed straight from the accepted operands.
    always_comb begin
        add_sum_s  = {1'b0, bus.in1} + {1'b0, bus.in2};
        sub_diff_s = bus.in1 - bus.in2;
    end

    // One iteration step. work_r holds {acc, multiplier} for mul and
    // {remainder, dividend/quotient} for div, so the final value is the result.
    always_comb begin
        work_nxt_s  = work_r;
        mul_sum_s   = {1'b0, work_r[2*W-1:W]} + {1'b0, opnd_r};
        div_shift_s = work_r[2*W-1:W-1];
        div_take_s  = (div_shift_s >= {1'b0, opnd_r});
        div_rem_s   = div_shift_s[W-1:0] - opnd_r;
        if (is_mul_r) begin
            if (work_r[0]) begin
                work_nxt_s = {mul_sum_s, work_r[W-1:1]};
            end else begin
                work_nxt_s = {1'b0, work_r[2*W-1:1]};
            end
        end else begin
            if (div_take_s) begin
                work_nxt_s = {div_rem_s, work_r[W-2:0], 1'b1};
            end else begin
                work_nxt_s = {div_shift_s[W-1:0], work_r[W-2:0], 1'b0};
            end
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            out_r      <= {(2*W){1'b0}};
            cnt_r      <= {CW{1'b0}};
            work_r     <= {(2*W){1'b0}};
            opnd_r     <= {W{1'b0}};
            is_mul_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        ready_r  <= 1'b0;
                        is_mul_r <= (bus.sel == OP_MUL);
                        case (bus.sel)
                            OP_ADD: begin
                                out_r      <= {{(W-1){1'b0}}, add_sum_s};
                                overflow_r <= add_sum_s[W];
                                done_r     <= 1'b1;
                                state_r    <= S_DONE;
                            end
                            OP_SUB: begin
                                out_r      <= {{W{1'b0}}, sub_diff_s};
                                overflow_r <= (bus.in1 < bus.in2);
                                done_r     <= 1'b1;
                                state_r    <= S_DONE;
                            end
                            OP_MUL: begin
                                work_r  <= {{W{1'b0}}, bus.in2};
                                opnd_r  <= bus.in1;
                                cnt_r   <= CW'(W);
                                state_r <= S_CALC;
                            end
                            OP_DIV: begin
                                if (bus.in2 == {W{1'b0}}) begin
                                    out_r      <= {bus.in1, {W{1'b1}}};
                                    overflow_r <= 1'b1;
                                    done_r     <= 1'b1;
                                    state_r    <= S_DONE;
                                end else begin
                                    work_r  <= {{W{1'b0}}, bus.in1};
                                    opnd_r  <= bus.in2;
                                    cnt_r   <= CW'(W);
                                    state_r <= S_CALC;
                                end
                            end
                            default: begin
                                ready_r <= 1'b1;
                                state_r <= S_IDLE;
                            end
                        endcase
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                S_CALC: begin
                    work_r <= work_nxt_s;
                    cnt_r  <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        out_r      <= work_nxt_s;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= S_DONE;
                    end else begin
                        state_r <= S_CALC;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule
